// File: rtl/imm_encode.sv
// Immediate-field encoder: captures Value/ImmSrc on Start, emits Instr[23:0] and Fail with a one-cycle Done strobe.
// Latency: L=1 cycle from the accepting edge, except class 00 with ROT_IMM_EN, where L=r+1 (first hit r) or 16 (no hit).
// Backpressure: Ready is high only in IDLE; Start is ignored while a request is in flight.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   Start            request strobe, sampled only while Ready=1
//   Value, ImmSrc    operand and encoding class (00 8-bit, 01 12-bit, 10 branch, 11 invalid)
//   Ready, Done      idle indicator, one-cycle result strobe
//   Instr, Fail      registered result; held until the next result or reset
//
// Build option: define ROT_IMM_EN to encode class 00 as an 8-bit value rotated by an even amount
// (one rotation tested per EVAL cycle). Without it, class 00 is a plain 8-bit zero-extended field.

module imm_encode (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] Value,
  input  logic [1:0]  ImmSrc,
  output logic        Ready,
  output logic        Done,
  output logic [23:0] Instr,
  output logic        Fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic [1:0]  src_q, src_d;
  logic [23:0] instr_q, instr_d;
  logic        fail_q, fail_d;

  // Result of the current EVAL cycle (res_vld=0 means keep searching).
  logic        res_vld;
  logic        res_fail;
  logic [23:0] res_instr;

`ifdef ROT_IMM_EN
  logic [3:0]  rot_q, rot_d;
  logic [4:0]  rot_sh;
  logic [31:0] rot_val;

  // ROL(val_q, 2r). For r=0 the right shift is by 32, which yields zero.
  always_comb begin
    rot_sh  = {rot_q, 1'b0};
    rot_val = (val_q << rot_sh) | (val_q >> (6'd32 - {1'b0, rot_sh}));
  end
`endif

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    src_d     = src_q;
    instr_d   = instr_q;
    fail_d    = fail_q;
    res_vld   = 1'b0;
    res_fail  = 1'b0;
    res_instr = 24'h000000;
`ifdef ROT_IMM_EN
    rot_d     = rot_q;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          val_d   = Value;
          src_d   = ImmSrc;
          state_d = EVAL;
`ifdef ROT_IMM_EN
          rot_d   = 4'd0;
`endif
        end
      end

      EVAL: begin
        case (src_q)
          2'b01: begin
            res_vld = 1'b1;
            if (val_q[31:12] == 20'h00000) res_instr = {12'h000, val_q[11:0]};
            else                           res_fail  = 1'b1;
          end
          2'b10: begin
            // Word-aligned branch offset whose upper bits are a sign extension of bit 25.
            res_vld = 1'b1;
            if (val_q[1:0] == 2'b00 && val_q[31:26] == {6{val_q[25]}}) res_instr = val_q[25:2];
            else                                                      res_fail  = 1'b1;
          end
          2'b11: begin
            res_vld  = 1'b1;
            res_fail = 1'b1;
          end
          default: begin
`ifdef ROT_IMM_EN
            if (rot_val[31:8] == 24'h000000) begin
              res_vld   = 1'b1;
              res_instr = {12'h000, rot_q, rot_val[7:0]};
            end else if (rot_q == 4'd15) begin
              res_vld  = 1'b1;
              res_fail = 1'b1;
            end else begin
              rot_d = rot_q + 4'd1;
            end
`else
            res_vld = 1'b1;
            if (val_q[31:8] == 24'h000000) res_instr = {16'h0000, val_q[7:0]};
            else                           res_fail  = 1'b1;
`endif
          end
        endcase

        if (res_vld) begin
          state_d = DONE;
          fail_d  = res_fail;
          instr_d = res_fail ? 24'h000000 : res_instr;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= 32'h00000000;
      src_q   <= 2'b00;
      instr_q <= 24'h000000;
      fail_q  <= 1'b0;
`ifdef ROT_IMM_EN
      rot_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      src_q   <= src_d;
      instr_q <= instr_d;
      fail_q  <= fail_d;
`ifdef ROT_IMM_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign Ready = (state_q == IDLE);
  assign Done  = (state_q == DONE);
  assign Instr = instr_q;
  assign Fail  = fail_q;

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 Start  input  1  request strobe; sampled only while Ready=1.
REQ-005 Value  input  32  target immediate value; captured at the accepting edge.
REQ-006 ImmSrc  input  2  encoding class: 00 8-bit, 01 12-bit unsigned, 10 branch, 11 invalid; captured at the accepting edge.
REQ-007 Ready  output  1  high only in IDLE.
REQ-008 Done  output  1  one-cycle result strobe.
REQ-009 Instr  output  24  encoded Instr[23:0] immediate field; bits not used by the class are 0.
REQ-010 Fail  output  1  Value is not representable in the class; valid with Done.

Function
REQ-011 FSM states SHALL be IDLE, EVAL and DONE. Transitions: IDLE->EVAL on Start; EVAL->DONE on result; DONE->IDLE unconditionally.
REQ-012 Acceptance SHALL occur at an edge where Start=1 and the state is IDLE. Start in other states SHALL be ignored. Value/ImmSrc changes after acceptance SHALL have no effect.
REQ-013 Latency L SHALL be counted from the accepting edge E0. Instr/Fail SHALL be registered at edge E0+L, and Done SHALL be high for exactly the following cycle.
REQ-014 Class 01 SHALL be encodable iff Value[31:12]==0, giving Instr={12'b0,Value[11:0]}; L=1.
REQ-015 Class 10 SHALL be encodable iff Value[1:0]==0 and Value[31:26] all equal Value[25], giving Instr=Value[25:2]; L=1.
REQ-016 Class 11 SHALL always set Fail=1; L=1.
REQ-017 Class 00 SHALL follow REQ-029/REQ-030.
REQ-018 On Fail=1, Instr SHALL be 0x000000.
REQ-019 Instr and Fail SHALL hold their last registered result until the next result or reset.
REQ-020 Ready SHALL be low from E0 through the Done cycle. A new Start SHALL be accepted at the edge ending the Done cycle's successor (IDLE).

Reset
REQ-021 Reset SHALL force state=IDLE, Ready=1, Done=0, Instr=0x000000, Fail=0, and the rotation counter to 0, independent of clk.
REQ-022 Reset asserted mid-EVAL or in DONE SHALL abort without producing Done. The first Start after reset deasserts SHALL be accepted normally.

Configuration
REQ-023 Macro ROT_IMM_EN SHALL select the class-00 algorithm.
REQ-024 The macro SHALL affect only class 00; the ports SHALL be identical with and without it.
REQ-025 Classes 01/10/11 SHALL be bit- and cycle-identical with and without the macro.
REQ-026 The rotation counter SHALL be 4 bits and SHALL NOT wrap past 15.
REQ-027 The rotation counter SHALL be reset to 0 at each acceptance.
REQ-028 The search SHALL stop at the first hit.
REQ-029 With ROT_IMM_EN defined, class 00 SHALL use the rotated immediate:
- In EVAL, one rotation r SHALL be tested per cycle, r=0..15 ascending.
- Hit condition: ROL(Value,2r)[31:8]==0.
- On the first hit: Instr={12'b0, r[3:0], ROL(Value,2r)[7:0]}, L=r+1.
- No hit after r=15: Fail=1, L=16.
REQ-030 With ROT_IMM_EN undefined, class 00 SHALL be encodable iff Value[31:8]==0, giving Instr={16'b0,Value[7:0]}, with L=1 and no rotation search.

Verification
REQ-031 ImmSrc=00, Value=0x000000AB -> L=1, Instr=0x0000AB, Fail=0 (both configurations).
REQ-032 ImmSrc=00, Value=0xFF000000 -> with ROT_IMM_EN: L=5, Instr=0x0004FF, Fail=0; without: L=1, Fail=1, Instr=0x000000.
REQ-033 ImmSrc=00, Value=0x00000101, ROT_IMM_EN -> L=16, Fail=1, Instr=0x000000; Ready low for 17 cycles.
REQ-034 ImmSrc=10: Value=0xFFFFFFF8 -> Instr=0xFFFFFE, Fail=0; Value=0x00000006 -> Fail=1.
REQ-035 ImmSrc=01: Value=0x00000FFF -> Instr=0x000FFF; Value=0x00001000 -> Fail=1. ImmSrc=11: any Value -> Fail=1, L=1.
REQ-036 Start Value=0x00000101 with ROT_IMM_EN, assert reset 5 cycles after acceptance -> Done never pulses, Instr=0, Fail=0, Ready=1. A subsequent ImmSrc=01, Value=0x123 -> Instr=0x000123 at L=1.
